tri_frame_rx: RTL and testbench

Serial front end that feeds the three-input parity/equivalence stage (the block producing S1 = X^Y^Z and S2 = Y~^Z). It deserialises a framed bit stream (start bit, three data bits X, Y, Z, parity bit, stop bit) and checks parity and framing. It presents each good frame as registered X, Y, Z with a valid/ready handshake, and keeps saturating counts of parity and framing errors.

---
 rtl/tri_frame_pkg.sv | 19 +
 rtl/tri_frame_rx_sat_counter.sv | 18 +
 rtl/tri_frame_rx.sv | 126 ++++++++++++
 tb/tb_tri_frame_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tri_frame_pkg.sv
// Shared types and constants for the tri_frame_rx serial front end:
// frame states and line levels for the start and stop bits.
package tri_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      D0,
      D1,
      D2,
      PAR,
      STOP,
      HOLD
   } state_t;

   localparam int   FRAME_BITS = 6;
   localparam logic START_LVL  = 1'b1;
   localparam logic STOP_LVL   = 1'b0;

endpackage

// File: rtl/tri_frame_rx_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tri_frame_rx.sv
// Deserialises start/X/Y/Z/parity/stop frames, delivers good frames through a
// valid/ready handshake and counts parity and framing errors.
module tri_frame_rx
   import tri_frame_pkg::*;
#(
   parameter int ODD   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_vld,
   output logic             din_rdy,
   output logic             X,
   output logic             Y,
   output logic             Z,
   output logic             par_ok,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [CNT_W-1:0] pe_cnt,
   output logic [CNT_W-1:0] fe_cnt
);

   localparam logic ODD_BIT = (ODD != 0);

   function automatic logic parity_good(input logic a, input logic b,
                                        input logic c, input logic p);
      return ((a ^ b ^ c ^ p) == ODD_BIT);
   endfunction

   state_t state, state_nxt;
   logic   accept;
   logic   cap_x, cap_y, cap_z, cap_p;
   logic   deliver, frame_err, release_frame;
   logic   sx, sy, sz, sp;
   logic   good_par;

   assign din_rdy  = (state != HOLD);
   assign accept   = din_vld & din_rdy;
   assign good_par = parity_good(sx, sy, sz, sp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      cap_x         = 1'b0;
      cap_y         = 1'b0;
      cap_z         = 1'b0;
      cap_p         = 1'b0;
      deliver       = 1'b0;
      frame_err     = 1'b0;
      release_frame = 1'b0;
      case (state)
         IDLE: if (accept && din == START_LVL) state_nxt = D0;
         D0:   if (accept) begin cap_x = 1'b1; state_nxt = D1;   end
         D1:   if (accept) begin cap_y = 1'b1; state_nxt = D2;   end
         D2:   if (accept) begin cap_z = 1'b1; state_nxt = PAR;  end
         PAR:  if (accept) begin cap_p = 1'b1; state_nxt = STOP; end
         STOP: begin
            if (accept) begin
               if (din == STOP_LVL) begin
                  deliver   = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  frame_err = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         HOLD: begin
            if (out_rdy) begin
               release_frame = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow registers: only the frame in flight, so no reset needed
   always_ff @(posedge clk) begin
      if (cap_x) sx <= din;
      if (cap_y) sy <= din;
      if (cap_z) sz <= din;
      if (cap_p) sp <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         X       <= 1'b0;
         Y       <= 1'b0;
         Z       <= 1'b0;
         par_ok  <= 1'b0;
         out_vld <= 1'b0;
      end else if (deliver) begin
         X       <= sx;
         Y       <= sy;
         Z       <= sz;
         par_ok  <= good_par;
         out_vld <= 1'b1;
      end else if (release_frame) begin
         out_vld <= 1'b0;
      end
   end

   // Parity errors still deliver the frame; framing errors drop it
   sat_counter #(.W(CNT_W)) u_pe_cnt (
      .clk (clk),
      .rst (rst),
      .inc (deliver & ~good_par),
      .cnt (pe_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fe_cnt (
      .clk (clk),
      .rst (rst),
      .inc (frame_err),
      .cnt (fe_cnt)
   );

endmodule

// File: tb/tb_tri_frame_rx.sv
// Directed bench for tri_frame_rx (ODD=1, CNT_W=2).
module tb_tri_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_vld = 1'b0;
   logic       din_rdy;
   logic       X, Y, Z;
   logic       par_ok;
   logic       out_vld;
   logic       out_rdy = 1'b0;
   logic [1:0] pe_cnt;
   logic [1:0] fe_cnt;

   int errors = 0;
   int checks = 0;

   tri_frame_rx #(.ODD(1), .CNT_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .din_vld (din_vld),
      .din_rdy (din_rdy),
      .X       (X),
      .Y       (Y),
      .Z       (Z),
      .par_ok  (par_ok),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .pe_cnt  (pe_cnt),
      .fe_cnt  (fe_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      din     = b;
      din_vld = 1'b1;
      @(posedge clk);
      #1;
      din_vld = 1'b0;
      din     = 1'b0;
   endtask

   // bits[5] goes first (start), bits[0] last (stop); gap idle cycles between bits
   task automatic send_frame(input logic [5:0] bits, input int gap);
      for (int i = 5; i >= 0; i--) begin
         if (i != 5)
            repeat (gap) begin @(posedge clk); #1; end
         send_bit(bits[i]);
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycle();

      check("rst_out_vld", out_vld, 1'b0);
      check("rst_xyz", {X, Y, Z}, 3'b000);
      check("rst_par_ok", par_ok, 1'b0);
      check("rst_din_rdy", din_rdy, 1'b1);
      check("rst_pe_cnt", pe_cnt, 2'd0);
      check("rst_fe_cnt", fe_cnt, 2'd0);

      // Good frame X=0 Y=1 Z=1 P=1
      out_rdy = 1'b1;
      send_frame(6'b101110, 0);
      check("f1_out_vld", out_vld, 1'b1);
      check("f1_xyz", {X, Y, Z}, 3'b011);
      check("f1_par_ok", par_ok, 1'b1);
      check("f1_din_rdy_hold", din_rdy, 1'b0);
      check("f1_pe_cnt", pe_cnt, 2'd0);
      check("f1_fe_cnt", fe_cnt, 2'd0);
      idle_cycle();
      check("f1_vld_drop", out_vld, 1'b0);
      check("f1_din_rdy_back", din_rdy, 1'b1);
      check("f1_xyz_kept", {X, Y, Z}, 3'b011);

      // X=Y=Z=1 P=0, with idle gaps inside the frame
      send_frame(6'b111100, 2);
      check("f2_out_vld", out_vld, 1'b1);
      check("f2_xyz", {X, Y, Z}, 3'b111);
      check("f2_par_ok", par_ok, 1'b1);
      check("f2_pe_cnt", pe_cnt, 2'd0);
      idle_cycle();

      // X=Y=Z=1 P=1: parity error but still delivered
      send_frame(6'b111110, 0);
      check("f3_out_vld", out_vld, 1'b1);
      check("f3_par_ok", par_ok, 1'b0);
      check("f3_pe_cnt", pe_cnt, 2'd1);
      idle_cycle();

      // Stop bit 1: framing error, frame dropped
      send_frame(6'b110011, 0);
      check("fe1_out_vld", out_vld, 1'b0);
      check("fe1_xyz_kept", {X, Y, Z}, 3'b111);
      check("fe1_fe_cnt", fe_cnt, 2'd1);
      check("fe1_din_rdy", din_rdy, 1'b1);
      check("fe1_pe_cnt", pe_cnt, 2'd1);

      // Back-pressure: X=0 Y=0 Z=0 P=1 with out_rdy low
      out_rdy = 1'b0;
      send_frame(6'b100010, 0);
      check("bp_out_vld", out_vld, 1'b1);
      check("bp_xyz", {X, Y, Z}, 3'b000);
      check("bp_par_ok", par_ok, 1'b1);
      for (int i = 0; i < 5; i++) begin
         din     = 1'b1;
         din_vld = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("bp_hold_vld_%0d", i), out_vld, 1'b1);
         check($sformatf("bp_hold_rdy_%0d", i), din_rdy, 1'b0);
      end
      din_vld = 1'b0;
      din     = 1'b0;
      out_rdy = 1'b1;
      idle_cycle();
      check("bp_release_vld", out_vld, 1'b0);
      check("bp_release_rdy", din_rdy, 1'b1);

      // Next frame must be aligned: nothing offered in HOLD was taken
      send_frame(6'b101010, 0);
      check("bp_next_vld", out_vld, 1'b1);
      check("bp_next_xyz", {X, Y, Z}, 3'b010);
      check("bp_next_par_ok", par_ok, 1'b0);
      check("bp_next_pe_cnt", pe_cnt, 2'd2);
      idle_cycle();

      // Reset after three accepted bits
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      #2;
      check("mid_rst_din_rdy", din_rdy, 1'b1);
      check("mid_rst_out_vld", out_vld, 1'b0);
      check("mid_rst_pe_cnt", pe_cnt, 2'd0);
      check("mid_rst_fe_cnt", fe_cnt, 2'd0);
      check("mid_rst_xyz", {X, Y, Z}, 3'b000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycle();
      send_frame(6'b110000, 0);
      check("post_rst_vld", out_vld, 1'b1);
      check("post_rst_xyz", {X, Y, Z}, 3'b100);
      check("post_rst_par_ok", par_ok, 1'b1);
      check("post_rst_pe_cnt", pe_cnt, 2'd0);
      idle_cycle();

      // Five framing errors: 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         send_frame(6'b100001, 0);
         check($sformatf("sat_fe_cnt_%0d", i), fe_cnt, (i < 3) ? (i + 1) : 3);
         check($sformatf("sat_out_vld_%0d", i), out_vld, 1'b0);
      end
      check("sat_xyz_kept", {X, Y, Z}, 3'b100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
